// File: rtl/moving_average3_hysteresis_if.sv
// Sample stream in, debounced level/event/peak/count out, for the
// moving-average hysteresis detector.
interface moving_average3_hysteresis_if;
  logic signed [7:0] input_0;
  logic              input_valid;
  logic              level_o;
  logic              rise_o;
  logic              fall_o;
  logic signed [7:0] peak_o;
  logic        [7:0] rise_count_o;

  modport master (
    output input_0, input_valid,
    input  level_o, rise_o, fall_o, peak_o, rise_count_o
  );

  modport slave (
    input  input_0, input_valid,
    output level_o, rise_o, fall_o, peak_o, rise_count_o
  );
endinterface

// File: rtl/moving_average3_hysteresis.sv
// Hysteretic, debounced level detector on a smoothed signed sample stream,
// with rise/fall pulses, per-excursion peak capture and a wrapping rise count.
module moving_average3_hysteresis #(
  parameter logic signed [7:0] HI_THRESH = 8'sd16,
  parameter logic signed [7:0] LO_THRESH = -8'sd16,
  parameter int                DEBOUNCE  = 3
) (
  input  logic                          system1000,
  input  logic                          system1000_rstn,
  moving_average3_hysteresis_if.slave   bus
);

  if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
    $error("moving_average3_hysteresis: LO_THRESH must be below HI_THRESH");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("moving_average3_hysteresis: DEBOUNCE must be in 1..255");
  end

  localparam logic [7:0] DEB = DEBOUNCE[7:0];

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_ARM_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_ARM_LOW  = 2'd3
  } state_t;

  function automatic logic signed [7:0] smax8(input logic signed [7:0] a,
                                              input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t            r_state, w_state_nxt;
  logic        [7:0] r_cnt, w_cnt_nxt;
  logic signed [7:0] r_pk, w_pk_nxt;
  logic              r_level, w_level_nxt;
  logic              r_rise, w_rise_nxt;
  logic              r_fall, w_fall_nxt;
  logic signed [7:0] r_peak, w_peak_nxt;
  logic        [7:0] r_rcount, w_rcount_nxt;

  logic signed [7:0] w_sample;
  logic              w_hi_q;
  logic              w_lo_q;
  logic signed [7:0] w_pk_max;

  assign w_sample = $signed(bus.input_0);
  assign w_hi_q   = (w_sample >= HI_THRESH);
  assign w_lo_q   = (w_sample <= LO_THRESH);
  assign w_pk_max = smax8(r_pk, w_sample);

  // State, debounce counter, peak tracker and registered outputs
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      r_state  <= ST_LOW;
      r_cnt    <= 8'd0;
      r_pk     <= 8'sd0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_peak   <= 8'sd0;
      r_rcount <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pk     <= w_pk_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_peak   <= w_peak_nxt;
      r_rcount <= w_rcount_nxt;
    end
  end

  // Next-state and next-output decode; invalid cycles hold everything
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pk_nxt     = r_pk;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_peak_nxt   = r_peak;
    w_rcount_nxt = r_rcount;

    if (bus.input_valid) begin
      case (r_state)
        ST_LOW: begin
          if (w_hi_q) begin
            w_pk_nxt = w_sample;
            if (DEB == 8'd1) begin
              w_state_nxt  = ST_HIGH;
              w_cnt_nxt    = 8'd0;
              w_rise_nxt   = 1'b1;
              w_rcount_nxt = r_rcount + 8'd1;
            end else begin
              w_state_nxt = ST_ARM_HIGH;
              w_cnt_nxt   = 8'd1;
            end
          end else begin
            w_cnt_nxt = 8'd0;
          end
        end
        ST_ARM_HIGH: begin
          w_pk_nxt = w_pk_max;
          if (w_hi_q) begin
            if (r_cnt + 8'd1 == DEB) begin
              w_state_nxt  = ST_HIGH;
              w_cnt_nxt    = 8'd0;
              w_rise_nxt   = 1'b1;
              w_rcount_nxt = r_rcount + 8'd1;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end else begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = 8'd0;
          end
        end
        ST_HIGH: begin
          w_pk_nxt = w_pk_max;
          if (w_lo_q) begin
            if (DEB == 8'd1) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = 8'd0;
              w_fall_nxt  = 1'b1;
              w_peak_nxt  = w_pk_max;
            end else begin
              w_state_nxt = ST_ARM_LOW;
              w_cnt_nxt   = 8'd1;
            end
          end else begin
            w_cnt_nxt = 8'd0;
          end
        end
        ST_ARM_LOW: begin
          w_pk_nxt = w_pk_max;
          if (w_lo_q) begin
            if (r_cnt + 8'd1 == DEB) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = 8'd0;
              w_fall_nxt  = 1'b1;
              w_peak_nxt  = w_pk_max;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end else begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = 8'd0;
          end
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end

    w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_ARM_LOW);
  end

  assign bus.level_o      = r_level;
  assign bus.rise_o       = r_rise;
  assign bus.fall_o       = r_fall;
  assign bus.peak_o       = r_peak;
  assign bus.rise_count_o = r_rcount;

endmodule

// File: tb/tb_moving_average3_hysteresis.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized stimulus against a run-length reference model.
module tb_moving_average3_hysteresis;

  localparam int HI = 16;
  localparam int LO = -16;
  localparam int D  = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  moving_average3_hysteresis_if bus ();

  moving_average3_hysteresis #(
    .HI_THRESH(8'sd16),
    .LO_THRESH(-8'sd16),
    .DEBOUNCE (3)
  ) dut (
    .system1000     (clk),
    .system1000_rstn(rstn),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current level plus length of the current run of
  // samples qualifying for the opposite level.
  bit                m_level;
  int                m_run;
  int                m_pk;
  logic signed [7:0] m_peak;
  logic        [7:0] m_count;
  bit                m_rise;
  bit                m_fall;

  task automatic model_reset();
    m_level = 1'b0; m_run = 0; m_pk = 0;
    m_peak = 8'sd0; m_count = 8'd0; m_rise = 1'b0; m_fall = 1'b0;
  endtask

  task automatic model_step(input bit v, input int s);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (v) begin
      if (!m_level) begin
        if (s >= HI) begin
          m_run++;
          m_pk = (m_run == 1) ? s : ((s > m_pk) ? s : m_pk);
        end else begin
          m_run = 0;
        end
        if (m_run == D) begin
          m_level = 1'b1; m_rise = 1'b1; m_count = m_count + 8'd1; m_run = 0;
        end
      end else begin
        if (s > m_pk) m_pk = s;
        if (s <= LO) m_run++;
        else         m_run = 0;
        if (m_run == D) begin
          m_level = 1'b0; m_fall = 1'b1; m_peak = 8'(m_pk); m_run = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " level"}, {7'd0, bus.level_o}, {7'd0, m_level});
    chk({tag, " rise"},  {7'd0, bus.rise_o},  {7'd0, m_rise});
    chk({tag, " fall"},  {7'd0, bus.fall_o},  {7'd0, m_fall});
    chk({tag, " peak"},  bus.peak_o,          m_peak);
    chk({tag, " count"}, bus.rise_count_o,    m_count);
  endtask

  // Present one sample, clock it in, advance the model, sample outputs at +1
  task automatic step(input bit v, input logic signed [7:0] s);
    bus.input_valid = v;
    bus.input_0     = s;
    @(posedge clk);
    if (rstn) model_step(v, int'(s));
    else      model_reset();
    #1;
  endtask

  task automatic do_reset(input logic signed [7:0] s);
    rstn = 1'b0;
    step(1'b1, s);
    rstn = 1'b1;
    chk("reset level", {7'd0, bus.level_o}, 8'd0);
    chk("reset rise",  {7'd0, bus.rise_o},  8'd0);
    chk("reset fall",  {7'd0, bus.fall_o},  8'd0);
    chk("reset peak",  bus.peak_o,          8'd0);
    chk("reset count", bus.rise_count_o,    8'd0);
  endtask

  typedef struct {
    bit                v;
    logic signed [7:0] s;
    bit                lvl;
    bit                rise;
    bit                fall;
    logic signed [7:0] peak;
    logic        [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input int s, input bit lvl, input bit r,
                     input bit f, input int pk, input int c);
    vec_t e;
    e.v = v; e.s = 8'(s); e.lvl = lvl; e.rise = r; e.fall = f;
    e.peak = 8'(pk); e.cnt = 8'(c);
    tbl.push_back(e);
  endtask

  initial begin
    bus.input_valid = 1'b0;
    bus.input_0     = 8'sd0;

    // Rise after three 20s, then excursion with peak 90
    add(1, 0,   0, 0, 0, 0, 0);
    add(1, 20,  0, 0, 0, 0, 0);
    add(1, 20,  0, 0, 0, 0, 0);
    add(1, 20,  1, 1, 0, 0, 1);
    add(1, 20,  1, 0, 0, 0, 1);
    add(1, 40,  1, 0, 0, 0, 1);
    add(1, 90,  1, 0, 0, 0, 1);
    add(1, 30,  1, 0, 0, 0, 1);
    add(1, -20, 1, 0, 0, 0, 1);
    add(1, -20, 1, 0, 0, 0, 1);
    add(1, -20, 0, 0, 1, 90, 1);
    // Broken run: no rise
    add(1, 20,  0, 0, 0, 90, 1);
    add(1, 20,  0, 0, 0, 90, 1);
    add(1, 5,   0, 0, 0, 90, 1);
    add(1, 20,  0, 0, 0, 90, 1);
    add(1, 20,  0, 0, 0, 90, 1);
    add(1, 5,   0, 0, 0, 90, 1);
    // Invalid gaps neither break nor extend the run
    add(1, 20,  0, 0, 0, 90, 1);
    add(0, 127, 0, 0, 0, 90, 1);
    add(0, -128,0, 0, 0, 90, 1);
    add(0, 5,   0, 0, 0, 90, 1);
    add(0, 20,  0, 0, 0, 90, 1);
    add(1, 20,  0, 0, 0, 90, 1);
    add(1, 20,  1, 1, 0, 90, 2);
    // Held in HIGH by interrupted low runs
    add(1, 0,   1, 0, 0, 90, 2);
    add(1, -20, 1, 0, 0, 90, 2);
    add(1, -20, 1, 0, 0, 90, 2);
    add(1, 0,   1, 0, 0, 90, 2);
    add(1, -30, 1, 0, 0, 90, 2);
    add(1, 0,   1, 0, 0, 90, 2);
    add(0, -30, 1, 0, 0, 90, 2);
    add(1, -20, 1, 0, 0, 90, 2);
    add(1, -30, 1, 0, 0, 90, 2);
    add(0, 100, 1, 0, 0, 90, 2);
    add(1, -16, 0, 0, 1, 20, 2);

    model_reset();
    do_reset(8'sd20);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s);
      chk($sformatf("tbl[%0d] level", i), {7'd0, bus.level_o}, {7'd0, tbl[i].lvl});
      chk($sformatf("tbl[%0d] rise", i),  {7'd0, bus.rise_o},  {7'd0, tbl[i].rise});
      chk($sformatf("tbl[%0d] fall", i),  {7'd0, bus.fall_o},  {7'd0, tbl[i].fall});
      chk($sformatf("tbl[%0d] peak", i),  bus.peak_o,          tbl[i].peak);
      chk($sformatf("tbl[%0d] count", i), bus.rise_count_o,    tbl[i].cnt);
    end

    // 256 excursions from reset wrap the rise counter back to zero
    do_reset(-8'sd20);
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < D; k++) step(1'b1, 8'(HI + n % 50));
      for (int k = 0; k < D; k++) step(1'b1, 8'(LO - k));
      chk_model($sformatf("wrap[%0d]", n));
      if (n == 254) chk("count at 255", bus.rise_count_o, 8'd255);
    end
    chk("count wrapped", bus.rise_count_o, 8'd0);
    chk("wrap last peak", bus.peak_o, 8'(HI + 255 % 50));

    // Reset while arming low discards the excursion without a fall pulse
    step(1'b1, 8'sd60);
    step(1'b1, 8'sd60);
    step(1'b1, 8'sd60);
    chk("pre-reset count", bus.rise_count_o, 8'd1);
    step(1'b1, -8'sd40);
    step(1'b1, -8'sd40);
    chk("arm_low level", {7'd0, bus.level_o}, 8'd1);
    do_reset(-8'sd40);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      logic signed [7:0] s;
      bit v;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       s = 8'($urandom_range(HI - 2, 127));
        1:       s = 8'(-int'($urandom_range(-LO - 2, 128)));
        default: s = 8'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) rstn = 1'b0;
      step(v, s);
      rstn = 1'b1;
      chk_model($sformatf("rand[%0d]", n));
      if (bus.rise_o && bus.fall_o) chk("rise&fall exclusive", 8'd1, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
